// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and memory (slave).
// One req/ack beat per word; mem_rdata is valid with mem_ack.
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: captures a core access, runs one (or two, when split) req/ack bus beats
// and returns extended load data. Define MISALIGN_SPLIT_EN to split misaligned half/word accesses.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  whb,
  input  logic        su,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  mem_access_ctrl_if.master bus
);
`ifdef MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, RESP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, RESP = 2'd3} state_t;
`endif

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  logic [7:0]  cnt;
  logic        rw_q, su_q, err_q;
  logic [1:0]  whb_q;
  logic [31:0] addr_q, wdata_q, lo_q;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [7:0]  be_cat;
  logic [63:0] wd_cat, rd_cat;
  logic [31:0] rd_sh, ld_val;
  logic        hi_beat, bad_in, req;
  logic        take, ld_lo, fin, fail, cnt_clr, cnt_inc;

  // Reject illegal size, and misalignment that cannot be split, before any bus cycle
  always_comb begin
    bad_in = (whb == 2'b11);
`ifndef MISALIGN_SPLIT_EN
    if (whb == 2'b01 && addr[0])            bad_in = 1'b1;
    if (whb == 2'b10 && addr[1:0] != 2'b00) bad_in = 1'b1;
`endif
  end

  assign off = addr_q[1:0];

  always_comb begin
    case (whb_q)
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
  end

  // Lane placement over an 8-byte window: low half is the first word, high half the second
  assign be_cat = {4'b0000, mask} << off;
  assign wd_cat = {32'h0, wdata_q} << {off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
  logic split;
  assign split   = |be_cat[7:4];
  assign hi_beat = (state == ACC1);
`else
  assign hi_beat = 1'b0;
`endif

  assign rd_cat = hi_beat ? {bus.mem_rdata, lo_q} : {32'h0, bus.mem_rdata};
  assign rd_sh  = 32'(rd_cat >> {off, 3'b000});

  always_comb begin
    case (whb_q)
      2'b00:   ld_val = {{24{su_q & rd_sh[7]}},  rd_sh[7:0]};
      2'b01:   ld_val = {{16{su_q & rd_sh[15]}}, rd_sh[15:0]};
      default: ld_val = rd_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    req     = 1'b0;
    take    = 1'b0;
    ld_lo   = 1'b0;
    fin     = 1'b0;
    fail    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE: if (start) begin
        take = 1'b1;
        if (bad_in) begin
          state_d = RESP;
          fail    = 1'b1;
        end else begin
          state_d = ACC0;
          cnt_clr = 1'b1;
        end
      end
      ACC0: begin
        req = 1'b1;
        // ack is checked before the timeout so a last-cycle ack still completes cleanly
        if (bus.mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
          if (split) begin
            state_d = ACC1;
            ld_lo   = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            state_d = RESP;
            fin     = 1'b1;
          end
`else
          state_d = RESP;
          fin     = 1'b1;
`endif
        end else if (cnt == TO_LAST) begin
          state_d = RESP;
          fail    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ACC1: begin
        req = 1'b1;
        if (bus.mem_ack) begin
          state_d = RESP;
          fin     = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_d = RESP;
          fail    = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      su_q    <= 1'b0;
      whb_q   <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      cnt     <= 8'h0;
      err_q   <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      if (take) begin
        rw_q    <= rw;
        su_q    <= su;
        whb_q   <= whb;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (cnt_clr)      cnt <= 8'h0;
      else if (cnt_inc) cnt <= cnt + 8'h1;
      if (ld_lo) lo_q <= bus.mem_rdata;
      if (fail) begin
        err_q <= 1'b1;
        rdata <= 32'h0;
      end else if (fin) begin
        err_q <= 1'b0;
        if (rw_q) rdata <= ld_val;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == RESP);
  assign err  = done & err_q;

  // Bus fields come from captured registers, so they hold steady for the whole beat
  assign bus.mem_req   = req;
  assign bus.mem_we    = req & ~rw_q;
  assign bus.mem_addr  = req ? ({addr_q[31:2], 2'b00} + (hi_beat ? 32'd4 : 32'd0)) : 32'h0;
  assign bus.mem_be    = req ? (hi_beat ? be_cat[7:4] : be_cat[3:0]) : 4'h0;
  assign bus.mem_wdata = req ? (hi_beat ? wd_cat[63:32] : wd_cat[31:0]) : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a vector table of single accesses plus hand sequences
// for split, timeout and mid-access reset. Inputs change and outputs are sampled on negedge.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rw, su;
  logic [1:0]  whb;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, err;

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .whb(whb), .su(su),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          beats, lat, req_cyc;
  bit          unstable, got_done, got_err, done_busy;
  logic [31:0] b_addr [2];
  logic [3:0]  b_be   [2];
  logic        b_we   [2];
  logic [31:0] b_wd   [2];

  typedef struct {
    logic        r;
    logic [1:0]  w;
    logic        s;
    logic [31:0] a, d, rd;
    int          nw;
    logic        e;
    logic [31:0] ea;
    logic [3:0]  eb;
    logic [31:0] ewd;
    int          lat;
    logic [31:0] er;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Issue one access and act as memory: ack each beat after nw wait cycles (nw<0: never ack)
  task automatic access(input logic r, input logic [1:0] w, input logic s, input logic [31:0] a,
                        input logic [31:0] d, input int nw, input logic [31:0] r0, input logic [31:0] r1);
    int left;
    bit fresh;
    int bi;
    beats = 0; unstable = 0; lat = 0; got_done = 0; got_err = 0; req_cyc = 0; done_busy = 0;
    rw = r; whb = w; su = s; addr = a; wdata = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0; left = nw; fresh = 1;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin
        lat = c; got_done = 1; got_err = err; done_busy = busy;
        break;
      end
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'hBAD0BAD0;
      if (bus.mem_req) begin
        req_cyc++;
        bi = (beats > 1) ? 1 : beats;
        if (fresh) begin
          b_addr[bi] = bus.mem_addr; b_be[bi] = bus.mem_be;
          b_we[bi] = bus.mem_we;     b_wd[bi] = bus.mem_wdata;
          fresh = 0;
        end else if (bus.mem_addr !== b_addr[bi] || bus.mem_be !== b_be[bi] ||
                     bus.mem_we !== b_we[bi] || bus.mem_wdata !== b_wd[bi]) begin
          unstable = 1;
        end
        if (nw >= 0 && left == 0) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = (beats == 0) ? r0 : r1;
          beats++; fresh = 1; left = nw;
        end else begin
          left--;
        end
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; su = 1'b0; whb = 2'b00; addr = 32'h0; wdata = 32'h0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    //          r  w      s  addr       wdata         mem_rdata     nw e  ea         eb       ewd           lat er
    vt[0]  = '{1, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 32'h100, 4'b1111, 32'h0,        2, 32'hDEADBEEF};
    vt[1]  = '{1, 2'b00, 1, 32'h103, 32'h0,        32'h80123456, 0, 0, 32'h100, 4'b1000, 32'h0,        2, 32'hFFFFFF80};
    vt[2]  = '{1, 2'b00, 0, 32'h103, 32'h0,        32'h80123456, 0, 0, 32'h100, 4'b1000, 32'h0,        2, 32'h00000080};
    vt[3]  = '{0, 2'b01, 0, 32'h202, 32'h0000ABCD, 32'h0,        3, 0, 32'h200, 4'b1100, 32'hABCD0000, 5, 32'h00000080};
    vt[4]  = '{1, 2'b01, 1, 32'h002, 32'h0,        32'h80011234, 1, 0, 32'h000, 4'b1100, 32'h0,        3, 32'hFFFF8001};
    vt[5]  = '{1, 2'b01, 0, 32'h000, 32'h0,        32'h1234F00D, 0, 0, 32'h000, 4'b0011, 32'h0,        2, 32'h0000F00D};
    vt[6]  = '{0, 2'b00, 0, 32'h011, 32'h000000A5, 32'h0,        2, 0, 32'h010, 4'b0010, 32'h0000A500, 4, 32'h0000F00D};
    vt[7]  = '{1, 2'b11, 0, 32'h040, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        1, 32'h0};
    vt[8]  = '{0, 2'b10, 0, 32'h300, 32'h12345678, 32'h0,        0, 0, 32'h300, 4'b1111, 32'h12345678, 2, 32'h0};
    vt[9]  = '{1, 2'b00, 1, 32'h001, 32'h0,        32'h00007F00, 0, 0, 32'h000, 4'b0010, 32'h0,        2, 32'h0000007F};
`ifdef MISALIGN_SPLIT_EN
    vt[10] = '{1, 2'b01, 0, 32'h001, 32'h0,        32'h00ABCD00, 0, 0, 32'h000, 4'b0110, 32'h0,        2, 32'h0000ABCD};
`else
    vt[10] = '{1, 2'b01, 0, 32'h001, 32'h0,        32'h00ABCD00, 0, 1, 32'h0,   4'b0000, 32'h0,        1, 32'h0};
`endif

    #1;
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.busy", {31'h0, busy}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    chk("rst.err", {31'h0, err}, 32'h0);
    chk("rst.req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst.we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst.addr", bus.mem_addr, 32'h0);
    chk("rst.be", {28'h0, bus.mem_be}, 32'h0);
    chk("rst.wdata", bus.mem_wdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      access(vt[i].r, vt[i].w, vt[i].s, vt[i].a, vt[i].d, vt[i].nw, vt[i].rd, 32'h0);
      chk($sformatf("v%0d.done", i), {31'h0, got_done}, 32'h1);
      chk($sformatf("v%0d.lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d.err", i), {31'h0, got_err}, {31'h0, vt[i].e});
      chk($sformatf("v%0d.rdata", i), rdata, vt[i].er);
      chk($sformatf("v%0d.reqcyc", i), req_cyc, vt[i].e ? 0 : vt[i].nw + 1);
      chk($sformatf("v%0d.busy_done", i), {31'h0, done_busy}, 32'h1);
      chk($sformatf("v%0d.busy_idle", i), {31'h0, busy}, 32'h0);
      if (!vt[i].e) begin
        chk($sformatf("v%0d.addr", i), b_addr[0], vt[i].ea);
        chk($sformatf("v%0d.be", i), {28'h0, b_be[0]}, {28'h0, vt[i].eb});
        chk($sformatf("v%0d.we", i), {31'h0, b_we[0]}, {31'h0, ~vt[i].r});
        chk($sformatf("v%0d.wdata", i), b_wd[0], vt[i].ewd);
        chk($sformatf("v%0d.stable", i), {31'h0, unstable}, 32'h0);
      end
    end

    // Misaligned word access
`ifdef MISALIGN_SPLIT_EN
    access(1, 2'b10, 0, 32'h101, 32'h0, 0, 32'h44332211, 32'h88776655);
    chk("lw_split.beats", beats, 2);
    chk("lw_split.addr0", b_addr[0], 32'h100);
    chk("lw_split.be0", {28'h0, b_be[0]}, 32'hE);
    chk("lw_split.addr1", b_addr[1], 32'h104);
    chk("lw_split.be1", {28'h0, b_be[1]}, 32'h1);
    chk("lw_split.lat", lat, 3);
    chk("lw_split.err", {31'h0, got_err}, 32'h0);
    chk("lw_split.rdata", rdata, 32'h55443322);
    access(0, 2'b10, 0, 32'h103, 32'hAABBCCDD, 0, 32'h0, 32'h0);
    chk("sw_split.be0", {28'h0, b_be[0]}, 32'h8);
    chk("sw_split.wd0", b_wd[0], 32'hDD000000);
    chk("sw_split.addr1", b_addr[1], 32'h104);
    chk("sw_split.be1", {28'h0, b_be[1]}, 32'h7);
    chk("sw_split.wd1", b_wd[1], 32'h00AABBCC);
    chk("sw_split.we1", {31'h0, b_we[1]}, 32'h1);
    chk("sw_split.lat", lat, 3);
    chk("sw_split.rdata", rdata, 32'h55443322);
`else
    access(1, 2'b10, 0, 32'h100, 32'h0, 0, 32'h11111111, 32'h0);
    access(1, 2'b10, 0, 32'h101, 32'h0, 0, 32'h44332211, 32'h0);
    chk("lw_mis.lat", lat, 1);
    chk("lw_mis.err", {31'h0, got_err}, 32'h1);
    chk("lw_mis.reqcyc", req_cyc, 0);
    chk("lw_mis.rdata", rdata, 32'h0);
`endif

    // Timeout: ack never arrives
    access(1, 2'b10, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h0);
    access(1, 2'b10, 0, 32'h000, 32'h0, -1, 32'h0, 32'h0);
    chk("to.done", {31'h0, got_done}, 32'h1);
    chk("to.reqcyc", req_cyc, 16);
    chk("to.lat", lat, 17);
    chk("to.err", {31'h0, got_err}, 32'h1);
    chk("to.rdata", rdata, 32'h0);
    // Ack on the last allowed cycle wins over the timeout
    access(1, 2'b10, 0, 32'h000, 32'h0, 15, 32'hCAFEF00D, 32'h0);
    chk("to_edge.reqcyc", req_cyc, 16);
    chk("to_edge.err", {31'h0, got_err}, 32'h0);
    chk("to_edge.rdata", rdata, 32'hCAFEF00D);
    access(1, 2'b10, 0, 32'h000, 32'h0, 0, 32'h01020304, 32'h0);
    chk("after_to.lat", lat, 2);
    chk("after_to.rdata", rdata, 32'h01020304);

    // Reset while a load is on the bus
    rw = 1'b1; whb = 2'b10; su = 1'b0; addr = 32'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rst_mid.req_before", {31'h0, bus.mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_mid.busy", {31'h0, busy}, 32'h0);
    chk("rst_mid.done", {31'h0, done}, 32'h0);
    chk("rst_mid.rdata", rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid.done_after", {31'h0, done}, 32'h0);
    access(1, 2'b10, 0, 32'h000, 32'h0, 0, 32'h0F0F0F0F, 32'h0);
    chk("rst_mid.lat", lat, 2);
    chk("rst_mid.new_rdata", rdata, 32'h0F0F0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
